// File: rtl/col_req_latch.sv
// Per-column event latch: each column buffers up to two events and requests
// service from a column arbiter; overflowing events are counted as drops.
module col_req_latch #(
    parameter int WIDTH     = 8,
    parameter int Y_WIDTH   = 3,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 enable_i,
    input  logic [WIDTH-1:0]     event_i,
    input  logic [WIDTH-1:0]     gnt_i,
    output logic [WIDTH-1:0]     req_o,
    output logic                 evt_valid_o,
    output logic [Y_WIDTH-1:0]   evt_yadd_o,
    output logic                 drop_o,
    output logic [CNT_WIDTH-1:0] drop_cnt_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam logic [1:0] ST_EMPTY    = 2'd0;
    localparam logic [1:0] ST_REQ      = 2'd1;
    localparam logic [1:0] ST_REQ_PEND = 2'd2;

    localparam int SUM_W = CNT_WIDTH + $clog2(WIDTH + 1) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_WIDTH{1'b1}});

    logic [WIDTH-1:0][1:0]  state_reg;
    logic [WIDTH-1:0][1:0]  state_next;
    logic [WIDTH-1:0]       req_reg;
    logic [WIDTH-1:0]       req_next;
    logic [WIDTH-1:0]       consume;
    logic [WIDTH-1:0]       drop_vec;
    logic                   grant_ok;
    logic                   proto_err;
    logic                   evt_valid_reg;
    logic                   evt_valid_next;
    logic [Y_WIDTH-1:0]     evt_yadd_reg;
    logic [Y_WIDTH-1:0]     evt_yadd_next;
    logic                   drop_reg;
    logic                   drop_next;
    logic [CNT_WIDTH-1:0]   drop_cnt_reg;
    logic [CNT_WIDTH-1:0]   drop_cnt_next;
    logic [SUM_W-1:0]       drop_sum;
    logic                   busy_reg;
    logic                   busy_next;
    logic                   err_reg;
    logic                   err_next;

    // A malformed grant consumes nothing, even on columns that are requesting.
    assign grant_ok  = enable_i && $onehot(gnt_i);
    assign consume   = grant_ok ? (gnt_i & req_reg) : '0;
    assign proto_err = enable_i && (((gnt_i != '0) && !$onehot(gnt_i)) ||
                                    ((gnt_i & ~req_reg) != '0));

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_col
            always_comb begin
                state_next[gi] = state_reg[gi];
                drop_vec[gi]   = 1'b0;
                case (state_reg[gi])
                    ST_EMPTY: begin
                        if (event_i[gi]) state_next[gi] = ST_REQ;
                    end
                    ST_REQ: begin
                        if (consume[gi] && !event_i[gi]) state_next[gi] = ST_EMPTY;
                        else if (!consume[gi] && event_i[gi]) state_next[gi] = ST_REQ_PEND;
                    end
                    ST_REQ_PEND: begin
                        if (consume[gi] && !event_i[gi]) state_next[gi] = ST_REQ;
                        drop_vec[gi] = event_i[gi] && !consume[gi];
                    end
                    default: state_next[gi] = ST_EMPTY;
                endcase
            end
            assign req_next[gi] = (state_next[gi] != ST_EMPTY);
        end
    endgenerate

    always_comb begin
        evt_valid_next = (consume != '0);
        evt_yadd_next  = evt_yadd_reg;
        for (int k = 0; k < WIDTH; k++) begin
            if (consume[k]) evt_yadd_next = Y_WIDTH'(k);
        end
        drop_sum = SUM_W'(drop_cnt_reg);
        for (int k = 0; k < WIDTH; k++) begin
            drop_sum = drop_sum + SUM_W'(drop_vec[k]);
        end
        drop_cnt_next = (drop_sum > CNT_MAX) ? {CNT_WIDTH{1'b1}} : drop_sum[CNT_WIDTH-1:0];
        drop_next     = (drop_vec != '0);
        busy_next     = (req_next != '0);
        err_next      = err_reg || proto_err;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_reg     <= '0;
            req_reg       <= '0;
            evt_valid_reg <= 1'b0;
            evt_yadd_reg  <= '0;
            drop_reg      <= 1'b0;
            drop_cnt_reg  <= '0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            req_reg       <= req_next;
            evt_valid_reg <= evt_valid_next;
            evt_yadd_reg  <= evt_yadd_next;
            drop_reg      <= drop_next;
            drop_cnt_reg  <= drop_cnt_next;
            busy_reg      <= busy_next;
            err_reg       <= err_next;
        end
    end

    assign req_o       = req_reg;
    assign evt_valid_o = evt_valid_reg;
    assign evt_yadd_o  = evt_yadd_reg;
    assign drop_o      = drop_reg;
    assign drop_cnt_o  = drop_cnt_reg;
    assign busy_o      = busy_reg;
    assign err_o       = err_reg;

endmodule

// File: tb/tb_col_req_latch.sv
// Directed bench for col_req_latch; consumed events are tracked in a queue
// of expected column indices pushed when a grant is driven.
module tb_col_req_latch;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       enable_i;
    logic [7:0] event_i;
    logic [7:0] gnt_i;
    logic [7:0] req_o;
    logic       evt_valid_o;
    logic [2:0] evt_yadd_o;
    logic       drop_o;
    logic [7:0] drop_cnt_o;
    logic       busy_o;
    logic       err_o;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    col_req_latch #(.WIDTH(8), .Y_WIDTH(3), .CNT_WIDTH(8)) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .enable_i    (enable_i),
        .event_i     (event_i),
        .gnt_i       (gnt_i),
        .req_o       (req_o),
        .evt_valid_o (evt_valid_o),
        .evt_yadd_o  (evt_yadd_o),
        .drop_o      (drop_o),
        .drop_cnt_o  (drop_cnt_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then score any consumed event against the queue.
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (evt_valid_o) begin
            if (exp_q.size() == 0) chk("evt_valid_spurious", 32'(evt_valid_o), 32'd0);
            else chk("evt_yadd", 32'(evt_yadd_o), 32'(exp_q.pop_front()));
        end
        if (exp_q.size() != 0) begin
            chk("evt_valid_missing", 32'(evt_valid_o), 32'd1);
            exp_q.delete();
        end
        $display("t=%0t ev=%02h gnt=%02h en=%0b rst_n=%0b | req=%02h vld=%0b y=%0d drop=%0b cnt=%0d busy=%0b err=%0b",
                 $time, event_i, gnt_i, enable_i, reset_n_i, req_o, evt_valid_o,
                 evt_yadd_o, drop_o, drop_cnt_o, busy_o, err_o);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   32'(req_o), 32'd0);
        chk({tag, "_vld"},   32'(evt_valid_o), 32'd0);
        chk({tag, "_yadd"},  32'(evt_yadd_o), 32'd0);
        chk({tag, "_drop"},  32'(drop_o), 32'd0);
        chk({tag, "_cnt"},   32'(drop_cnt_o), 32'd0);
        chk({tag, "_busy"},  32'(busy_o), 32'd0);
        chk({tag, "_err"},   32'(err_o), 32'd0);
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        tick();
        reset_n_i = 1'b1;
    endtask

    initial begin
        reset_n_i = 1'b0;
        enable_i  = 1'b1;
        event_i   = 8'h00;
        gnt_i     = 8'h00;
        tick();
        tick();
        chk_all_zero("reset");
        reset_n_i = 1'b1;

        // Single event on column 2
        event_i = 8'h04;
        tick();
        chk("single_req_t1", 32'(req_o), 32'h04);
        chk("single_busy_t1", 32'(busy_o), 32'd1);
        event_i = 8'h00;
        tick();
        chk("single_req_t2", 32'(req_o), 32'h04);
        gnt_i = 8'h04;
        exp_q.push_back(2);
        tick();
        chk("single_req_t3", 32'(req_o), 32'h00);
        chk("single_vld_t3", 32'(evt_valid_o), 32'd1);
        chk("single_busy_t3", 32'(busy_o), 32'd0);
        gnt_i = 8'h00;
        tick();
        chk("single_vld_off", 32'(evt_valid_o), 32'd0);
        chk("single_yadd_hold", 32'(evt_yadd_o), 32'd2);
        chk("single_err", 32'(err_o), 32'd0);

        // Overflow on column 5
        event_i = 8'h20;
        tick();
        chk("ovf_drop_1", 32'(drop_o), 32'd0);
        tick();
        chk("ovf_drop_2", 32'(drop_o), 32'd0);
        tick();
        chk("ovf_drop_3", 32'(drop_o), 32'd1);
        chk("ovf_cnt_3", 32'(drop_cnt_o), 32'd1);
        event_i = 8'h00;
        tick();
        chk("ovf_drop_off", 32'(drop_o), 32'd0);
        chk("ovf_req", 32'(req_o), 32'h20);
        gnt_i = 8'h20;
        exp_q.push_back(5);
        tick();
        chk("ovf_req_after_g1", 32'(req_o), 32'h20);
        exp_q.push_back(5);
        tick();
        chk("ovf_req_after_g2", 32'(req_o), 32'h00);
        gnt_i = 8'h00;
        tick();
        chk("ovf_cnt_hold", 32'(drop_cnt_o), 32'd1);

        // Simultaneous event and consume on column 0 in REQ
        event_i = 8'h01;
        tick();
        gnt_i = 8'h01;
        exp_q.push_back(0);
        tick();
        chk("sim_req", 32'(req_o), 32'h01);
        chk("sim_vld", 32'(evt_valid_o), 32'd1);
        chk("sim_drop", 32'(drop_o), 32'd0);
        event_i = 8'h00;

        // Grant ignored while disabled
        enable_i = 1'b0;
        gnt_i    = 8'h01;
        tick();
        chk("dis_req", 32'(req_o), 32'h01);
        chk("dis_vld", 32'(evt_valid_o), 32'd0);
        chk("dis_err", 32'(err_o), 32'd0);
        enable_i = 1'b1;
        exp_q.push_back(0);
        tick();
        chk("dis_drain_req", 32'(req_o), 32'h00);
        gnt_i = 8'h00;
        tick();

        // Non-one-hot grant while columns 0 and 1 request
        event_i = 8'h03;
        tick();
        event_i = 8'h00;
        gnt_i   = 8'h03;
        tick();
        chk("nonoh_err", 32'(err_o), 32'd1);
        chk("nonoh_req", 32'(req_o), 32'h03);
        chk("nonoh_vld", 32'(evt_valid_o), 32'd0);
        gnt_i = 8'h00;
        tick();
        chk("nonoh_err_held", 32'(err_o), 32'd1);
        do_reset();
        chk_all_zero("rst_mid");

        // Grant to an empty column
        gnt_i = 8'h08;
        tick();
        chk("empty_err", 32'(err_o), 32'd1);
        chk("empty_vld", 32'(evt_valid_o), 32'd0);
        chk("empty_req", 32'(req_o), 32'h00);
        gnt_i = 8'h00;
        tick();
        chk("empty_err_held", 32'(err_o), 32'd1);
        do_reset();
        chk("empty_err_clr", 32'(err_o), 32'd0);

        // Columns 1 and 6 to REQ_PEND, then saturate the drop counter
        event_i = 8'h42;
        tick();
        tick();
        chk("pend_req", 32'(req_o), 32'h42);
        chk("pend_drop", 32'(drop_o), 32'd0);
        tick();
        chk("dual_drop", 32'(drop_o), 32'd1);
        chk("dual_cnt", 32'(drop_cnt_o), 32'd2);
        for (int i = 0; i < 126; i++) tick();
        chk("sat_cnt_254", 32'(drop_cnt_o), 32'd254);
        event_i = 8'h02;
        tick();
        chk("sat_cnt_255", 32'(drop_cnt_o), 32'd255);
        event_i = 8'h42;
        tick();
        chk("sat_cnt_hold", 32'(drop_cnt_o), 32'd255);
        chk("sat_drop", 32'(drop_o), 32'd1);

        // Reset with events and grants present: everything discarded
        gnt_i     = 8'h42;
        reset_n_i = 1'b0;
        tick();
        chk_all_zero("rst_full");
        reset_n_i = 1'b1;
        event_i   = 8'h00;
        gnt_i     = 8'h00;
        tick();
        chk_all_zero("rst_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/col_req_latch.md
COL_REQ_LATCH -- requirements
Module: col_req_latch

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of columns.
REQ-002 The block SHALL have parameter Y_WIDTH, default 3, giving the column-index width (WIDTH <= 2**Y_WIDTH).
REQ-003 The block SHALL have parameter CNT_WIDTH, default 8, giving the drop-counter width.
REQ-004 Ports, in this order:
- clk_i  in  1  clock; single clock domain, all flops on the rising edge.
- reset_n_i  in  1  reset; synchronous, active-low.
- enable_i  in  1  high = grants are honoured.
- event_i  in  WIDTH  per-column event strobes, one cycle each.
- gnt_i  in  WIDTH  registered one-hot grant from the column arbiter.
- req_o  out  WIDTH  per-column request to the column arbiter.
- evt_valid_o  out  1  one-cycle pulse marking a consumed event.
- evt_yadd_o  out  Y_WIDTH  column index of the consumed event.
- drop_o  out  1  one-cycle pulse marking that at least one event was lost this cycle.
- drop_cnt_o  out  CNT_WIDTH  saturating count of lost events.
- busy_o  out  1  high when any column holds an event.
- err_o  out  1  sticky protocol-error flag.

Function
REQ-005 Each column SHALL hold a 2-deep occupancy state: EMPTY (0), REQ (1), REQ_PEND (2).
REQ-006 req_o[k] SHALL be registered and high exactly when column k is in REQ or REQ_PEND.
REQ-007 A column SHALL be consumed in a cycle when enable_i, gnt_i[k] and req_o[k] are all high.
REQ-008 Per-column transitions, evaluated each cycle:
- EMPTY + event -> REQ.
- REQ + event -> REQ_PEND.
- REQ + consume -> EMPTY.
- REQ_PEND + consume -> REQ.
- REQ + consume + event -> REQ.
- REQ_PEND + consume + event -> REQ_PEND.
- REQ_PEND + event without consume -> REQ_PEND, and the event is dropped.
REQ-009 Event-to-request latency SHALL be 1 cycle: event_i[k] at cycle t makes req_o[k] high at t+1 when the column was EMPTY.
REQ-010 Consume-to-release latency SHALL be 1 cycle: a consume at t makes req_o[k] low at t+1 when the column was REQ and received no event at t.
REQ-011 A consume at cycle t SHALL produce evt_valid_o=1 at t+1 with evt_yadd_o=k; otherwise evt_valid_o=0 and evt_yadd_o holds its last value.
REQ-012 A cycle with one or more dropped events SHALL produce drop_o=1 at t+1.
REQ-013 drop_cnt_o SHALL add the number of events dropped in the cycle, saturating at all ones.
REQ-014 While enable_i is low, gnt_i SHALL be ignored: no consume occurs and no error is raised.
REQ-015 While enable_i is low, events SHALL still be captured and req_o SHALL still reflect occupancy.
REQ-016 err_o SHALL set, and stay set until reset, when enable_i is high and gnt_i is non-zero and not one-hot.
REQ-017 err_o SHALL also set, and stay set until reset, when enable_i is high and gnt_i[k] is high while req_o[k] is low.
REQ-018 On a non-one-hot grant, no column SHALL be consumed that cycle.
REQ-019 On a grant to an empty column, state SHALL be unchanged and evt_valid_o SHALL stay 0.
REQ-020 busy_o SHALL be registered and equal the OR of req_o.
REQ-021 Events on different columns in the same cycle SHALL be captured independently with no loss.

Reset
REQ-022 When reset_n_i is low at a rising edge, every column SHALL become EMPTY and req_o, evt_valid_o, evt_yadd_o, drop_o, drop_cnt_o, busy_o and err_o SHALL all become 0.
REQ-023 Reset asserted mid-operation SHALL discard all held events with no evt_valid_o pulse.
REQ-024 Events and grants present during the reset cycle SHALL be ignored.

Verification
REQ-025 The bench SHALL cover these directed scenarios (WIDTH=8):
- Single event: event_i=8'h04 at t0, gnt_i=8'h04 at t2, enable_i=1 -> req_o=8'h04 at t1..t2; req_o=0, evt_valid_o=1 and evt_yadd_o=2 at t3.
- Overflow: three events on column 5 with no grant -> req_o[5]=1, one drop_o pulse, drop_cnt_o=1; two grants then give two evt_valid_o pulses with yadd=5, then req_o[5]=0.
- Simultaneous event and consume on column 0 in REQ -> req_o[0] stays 1, evt_valid_o=1, no drop.
- Protocol errors: gnt_i=8'h03, or a grant to an EMPTY column -> err_o=1 next cycle and held, no consume.
- Disable: enable_i=0 with gnt_i=8'h01 while column 0 is in REQ -> no consume, err_o=0, req_o[0] stays 1.
- Reset: reset_n_i=0 for 1 cycle while columns 1 and 6 are in REQ_PEND and drop_cnt_o=255 -> all outputs 0 next cycle; drop_cnt_o saturates at 255 before reset.
